// File: rtl/mram_pkg.sv
// Shared definitions for the MRAM macro emulator: field widths, LFSR taps,
// busy-FSM state encoding and the DMODE-to-latency mapping.
package mram_pkg;

    localparam int          ROW_W     = 7;
    localparam int          COL_W     = 4;
    localparam int          BYTE_W    = 8;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic {
        IDLE,
        RD_WAIT
    } state_e;

    // Read latency in clock edges, 1..4.
    function automatic logic [2:0] lat_of(input logic [1:0] dmode);
        return {1'b0, dmode} + 3'd1;
    endfunction

endpackage

// File: rtl/mram_emu_lfsr.sv
// 32-bit Galois LFSR (right-shifting) used as the switching-probability source
// for stochastic MTJ writes. Steps once per clock while en is high.
module mram_emu_lfsr
    import mram_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2468
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] lfsr_o
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/mram_emu.sv
// Byte-wide MRAM macro emulator: inferred array, DMODE-programmed read latency,
// sticky access-error flag. Define MRAM_EMU_TRNG_EN to add stochastic writes.
module mram_emu
    import mram_pkg::*;
#(
    parameter int          ROWS      = 128,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              csn,
    input  logic              wen,
    input  logic [ROW_W-1:0]  ROW_ADDR,
    input  logic [COL_W-1:0]  COL_ADDR,
    input  logic [BYTE_W-1:0] DATA,
    input  logic [5:0]        DMODE,
    input  logic [8:0]        TRNG_MODE,
    input  logic [1:0]        DETOUR,
    input  logic              RP_SEL,
    output logic [BYTE_W-1:0] OUTPUT,
    output logic              acc_err
);

    localparam int          DEPTH  = ROWS * 16;
    localparam int          AW     = $clog2(DEPTH);
    localparam logic [31:0] ROWS_U = ROWS;

    logic [BYTE_W-1:0] mem [DEPTH];

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d;
    logic              rd_oor_q, rd_oor_d;
    logic [BYTE_W-1:0] out_q, out_d;
    logic              err_q, err_d;

    logic [ROW_W+COL_W-1:0] addr_full;
    logic [AW-1:0]          addr_idx;
    logic                   in_range;
    logic                   done, accept, collide, wr_en, rd_go;
    logic [BYTE_W-1:0]      wmask;
    logic                   unused_ok;

    assign addr_full = {ROW_ADDR, COL_ADDR};
    assign addr_idx  = addr_full[AW-1:0];
    assign in_range  = ({25'd0, ROW_ADDR} < ROWS_U);

`ifdef MRAM_EMU_TRNG_EN
    logic [31:0] lfsr;

    mram_emu_lfsr #(
        .SEED   (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .en     (1'b1),
        .lfsr_o (lfsr)
    );

    // A bit switches when its LFSR nibble is below the threshold P.
    always_comb begin
        wmask = '1;
        if (TRNG_MODE[8]) begin
            for (int i = 0; i < BYTE_W; i++) begin
                wmask[i] = (lfsr[4*i +: 4] < TRNG_MODE[3:0]);
            end
        end
    end

    assign unused_ok = ^{DETOUR, RP_SEL, DMODE[5:2], TRNG_MODE[7:4]};
`else
    assign wmask     = '1;
    assign unused_ok = ^{DETOUR, RP_SEL, DMODE[5:2], TRNG_MODE, LFSR_SEED};
`endif

    always_comb begin
        done    = (state_q == RD_WAIT) && (cnt_q == 2'd0);
        accept  = !csn && ((state_q == IDLE) || done);
        collide = !csn && !accept;
        wr_en   = accept && !wen && in_range && !rst;
        rd_go   = accept && wen;

        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_addr_d = rd_addr_q;
        rd_oor_d  = rd_oor_q;
        out_d     = out_q;
        err_d     = err_q | collide | (accept && !in_range);

        if (state_q == RD_WAIT) begin
            if (done) begin
                out_d   = rd_oor_q ? '0 : mem[rd_addr_q];
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q - 2'd1;
            end
        end

        // A read accepted on the completion edge overrides the return to IDLE.
        if (rd_go) begin
            state_d   = RD_WAIT;
            cnt_d     = 2'(lat_of(DMODE[1:0]) - 3'd1);
            rd_addr_d = addr_idx;
            rd_oor_d  = !in_range;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr_idx] <= (mem[addr_idx] & ~wmask) | (DATA & wmask);
        end
        rd_addr_q <= rd_addr_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            rd_oor_q <= 1'b0;
            out_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_oor_q <= rd_oor_d;
            out_q    <= out_d;
            err_q    <= err_d;
        end
    end

    assign OUTPUT  = out_q;
    assign acc_err = err_q;

endmodule

// File: tb/tb_mram_emu.sv
// Directed self-checking bench for mram_emu (ROWS=64); the stochastic section
// is selected by MRAM_EMU_TRNG_EN.
`timescale 1ns/1ps
module tb_mram_emu;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       csn = 1'b1;
    logic       wen = 1'b1;
    logic [6:0] ROW_ADDR = '0;
    logic [3:0] COL_ADDR = '0;
    logic [7:0] DATA = '0;
    logic [5:0] DMODE = '0;
    logic [8:0] TRNG_MODE = '0;
    logic [1:0] DETOUR = '0;
    logic       RP_SEL = 1'b0;
    logic [7:0] OUTPUT;
    logic       acc_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mram_emu #(.ROWS(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .csn       (csn),
        .wen       (wen),
        .ROW_ADDR  (ROW_ADDR),
        .COL_ADDR  (COL_ADDR),
        .DATA      (DATA),
        .DMODE     (DMODE),
        .TRNG_MODE (TRNG_MODE),
        .DETOUR    (DETOUR),
        .RP_SEL    (RP_SEL),
        .OUTPUT    (OUTPUT),
        .acc_err   (acc_err)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All tasks start and end at a falling edge; one access is sampled per call.
    task automatic acc(input logic w, input logic [6:0] r, input logic [3:0] c,
                       input logic [7:0] d, input logic [5:0] dm, input logic [8:0] tm);
        csn = 1'b0; wen = w; ROW_ADDR = r; COL_ADDR = c; DATA = d; DMODE = dm; TRNG_MODE = tm;
        @(negedge clk);
        csn = 1'b1; wen = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [6:0] r, input logic [3:0] c, input logic [7:0] d,
                      input logic [8:0] tm);
        acc(1'b0, r, c, d, 6'h00, tm);
    endtask

    task automatic rd_chk(input string tag, input logic [6:0] r, input logic [3:0] c,
                          input logic [5:0] dm, input logic [7:0] prev, input logic [7:0] exp);
        int l;
        l = int'(dm[1:0]) + 1;
        acc(1'b1, r, c, 8'h00, dm, 9'h000);
        repeat (l - 1) @(negedge clk);
        chk({tag, "_early"}, OUTPUT, prev);
        @(negedge clk);
        chk(tag, OUTPUT, exp);
    endtask

    task automatic rd_val(input logic [6:0] r, input logic [3:0] c, output logic [7:0] v);
        acc(1'b1, r, c, 8'h00, 6'h00, 9'h000);
        @(negedge clk);
        v = OUTPUT;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        logic [7:0] cur;
        logic [7:0] nxt;
        logic [7:0] tgt;
        int tr [8];
        int sw [8];

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out", OUTPUT, 8'h00);
        chk("rst_err", {7'd0, acc_err}, 8'h00);
        rst = 1'b0;

        // Deterministic write / read with L=2
        wr(7'd1, 4'd14, 8'h12, 9'h000);
        rd_chk("rd_l2", 7'd1, 4'd14, 6'h15, 8'h00, 8'h12);
        chk("err_clean", {7'd0, acc_err}, 8'h00);

        // Latency sweep alternating between two bytes; DMODE[5:2] set to show they are ignored
        wr(7'd1, 4'd0, 8'h34, 9'h000);
        rd_chk("lat1", 7'd1, 4'd0,  6'h3C, 8'h12, 8'h34);
        rd_chk("lat2", 7'd1, 4'd14, 6'h3D, 8'h34, 8'h12);
        rd_chk("lat3", 7'd1, 4'd0,  6'h3E, 8'h12, 8'h34);
        rd_chk("lat4", 7'd1, 4'd14, 6'h3F, 8'h34, 8'h12);

        // Read-after-write on consecutive edges
        wr(7'd2, 4'd5, 8'h9C, 9'h000);
        rd_chk("raw", 7'd2, 4'd5, 6'h00, 8'h12, 8'h9C);

        // Back-to-back reads, L=2: second read sampled on the completion edge
        acc(1'b1, 7'd1, 4'd0, 8'h00, 6'h01, 9'h000);
        idle(1);
        acc(1'b1, 7'd2, 4'd5, 8'h00, 6'h01, 9'h000);
        chk("b2b_first", OUTPUT, 8'h34);
        idle(1);
        chk("b2b_hold", OUTPUT, 8'h34);
        idle(1);
        chk("b2b_second", OUTPUT, 8'h9C);
        chk("b2b_err", {7'd0, acc_err}, 8'h00);

        // Collision: write during RD_WAIT (L=4) is dropped and flagged
        wr(7'd3, 4'd3, 8'h0F, 9'h000);
        acc(1'b1, 7'd1, 4'd14, 8'h00, 6'h03, 9'h000);
        idle(1);
        acc(1'b0, 7'd3, 4'd3, 8'h55, 6'h00, 9'h000);
        chk("col_wait", OUTPUT, 8'h9C);
        idle(1);
        chk("col_wait2", OUTPUT, 8'h9C);
        idle(1);
        chk("col_data", OUTPUT, 8'h12);
        chk("col_err", {7'd0, acc_err}, 8'h01);
        rd_chk("col_drop", 7'd3, 4'd3, 6'h00, 8'h12, 8'h0F);
        chk("col_err_sticky", {7'd0, acc_err}, 8'h01);

        // Reset mid-read: OUTPUT cleared asynchronously, pending read discarded
        acc(1'b1, 7'd1, 4'd14, 8'h00, 6'h03, 9'h000);
        idle(1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_out", OUTPUT, 8'h00);
        chk("rst_clr_err", {7'd0, acc_err}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        chk("rst_discard", OUTPUT, 8'h00);

        // Out-of-range row (ROWS=64): write dropped, read returns 00, sticky flag
        wr(7'd36, 4'd0, 8'h11, 9'h000);
        rd_chk("pre_oor", 7'd1, 4'd14, 6'h00, 8'h00, 8'h12);
        wr(7'd100, 4'd0, 8'hAA, 9'h000);
        chk("oor_wr_err", {7'd0, acc_err}, 8'h01);
        rd_chk("oor_rd", 7'd100, 4'd0, 6'h01, 8'h12, 8'h00);
        rd_chk("oor_alias", 7'd36, 4'd0, 6'h00, 8'h00, 8'h11);
        idle(5);
        chk("oor_sticky", {7'd0, acc_err}, 8'h01);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("oor_rst_clr", {7'd0, acc_err}, 8'h00);

`ifdef MRAM_EMU_TRNG_EN
        // P=0 writes nothing
        wr(7'd4, 4'd0, 8'h00, 9'h000);
        wr(7'd4, 4'd0, 8'hFF, 9'h170);
        rd_val(7'd4, 4'd0, v);
        chk("p0_nowrite", v, 8'h00);

        // P=7: per-bit switching rate must sit in 7/16 +/- 0.05
        for (int b = 0; b < 8; b++) begin
            tr[b] = 0;
            sw[b] = 0;
        end
        cur = 8'h00;
        for (int k = 0; k < 1000; k++) begin
            for (int ph = 0; ph < 2; ph++) begin
                tgt = (ph == 0) ? 8'hFF : 8'h00;
                wr(7'd4, 4'd0, tgt, 9'h177);
                rd_val(7'd4, 4'd0, nxt);
                for (int b = 0; b < 8; b++) begin
                    if (cur[b] != tgt[b]) begin
                        tr[b]++;
                        if (nxt[b] == tgt[b]) sw[b]++;
                    end
                end
                cur = nxt;
                idle($urandom_range(0, 3));
            end
        end
        for (int b = 0; b < 8; b++) begin
            checks++;
            assert ((tr[b] > 0) && (sw[b] * 10000 >= tr[b] * 3875) && (sw[b] * 10000 <= tr[b] * 4875)) else begin
                errors++;
                $error("FAIL p7_rate_bit%0d: observed %0d of %0d switched, expected 7/16 +/- 0.05", b, sw[b], tr[b]);
            end
        end

        // Stochastic enable clear: deterministic write
        wr(7'd4, 4'd0, 8'hC3, 9'h077);
        rd_val(7'd4, 4'd0, v);
        chk("det_077", v, 8'hC3);
`else
        // Without the TRNG path every write is deterministic
        wr(7'd4, 4'd0, 8'h00, 9'h000);
        wr(7'd4, 4'd0, 8'hA5, 9'h170);
        rd_val(7'd4, 4'd0, v);
        chk("notrng_write", v, 8'hA5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mram_emu.md
# mram_emu

Synthesizable MRAM macro emulator: the responder on the byte-wide MRAM port driven by the TRNG controller (csn/wen/ROW_ADDR/COL_ADDR/DATA/DMODE/TRNG_MODE in, OUTPUT out). It replaces the hard macro in FPGA prototypes and in RTL regressions.
- Stores bytes in an inferred array and returns read data with a DMODE-programmed latency.
- Emulates stochastic (probabilistic) MTJ switching on writes, so the controller's TRNG flow produces non-trivial data.

## Interface
Parameters:
- ROWS, 128: number of implemented rows (1..128); rows at or above ROWS are out of range.
- LFSR_SEED, 32'hACE1_2468: LFSR reset value; must be non-zero.

Ports:
- clk  in  1  MRAM clock (the controller's clk_200).
- rst  in  1  asynchronous, active-high reset.
- csn  in  1  chip select, active low; an access is sampled on a rising clk edge with csn=0.
- wen  in  1  0 = write, 1 = read; qualified by csn=0.
- ROW_ADDR  in  7  row address.
- COL_ADDR  in  4  column (byte) address within the row.
- DATA  in  8  write data.
- DMODE  in  6  timing code; [1:0] selects the read latency; [5:2] are ignored.
- TRNG_MODE  in  9  [8] stochastic-write enable; [3:0] switching threshold P; [7:4] ignored.
- DETOUR  in  2  accepted, no functional effect.
- RP_SEL  in  1  accepted, no functional effect.
- OUTPUT  out  8  read data to the controller.
- acc_err  out  1  sticky access-error flag.

## Operation
- Storage is a mem[ROWS*16] array of bytes, indexed by {ROW_ADDR, COL_ADDR}. Array contents are not reset.
- Busy state machine, states IDLE and RD_WAIT, with a 2-bit countdown.
- Accept rule: an access (csn=0 at an edge) is accepted only in IDLE, or on the completion edge of RD_WAIT.
- Write (wen=0) in deterministic mode (TRNG_MODE[8]=0): mem[a] <= DATA at the sampling edge. The state machine stays in IDLE.
- Write in stochastic mode (TRNG_MODE[8]=1): for each bit i in 0..7, mem[a][i] <= DATA[i] if lfsr[4i+3:4i] < P; otherwise the bit is unchanged.
  - P=0: nothing is written.
  - P=15: each bit switches with probability 15/16.
- Read (wen=1):
  - Latch the address and set L = DMODE[1:0]+1 (range 1..4).
  - Enter RD_WAIT. OUTPUT <= mem[a] at the edge L cycles after the sampling edge.
  - Return to IDLE on that edge, unless a new access is accepted there.
- LFSR: 32-bit Galois, taps 32'h8020_0003. It advances on every clk edge while not in reset. A stochastic write uses the pre-advance value.
- Out-of-range row (ROW_ADDR >= ROWS):
  - Write: dropped.
  - Read: follows normal latency and returns 8'h00.
  - Both set acc_err.
- Collision: an access sampled in RD_WAIT before the completion edge is ignored (no write, no new read) and sets acc_err.
- acc_err is cleared only by rst.

## Timing
- Reset values: OUTPUT=8'h00, acc_err=0, state=IDLE, lfsr=LFSR_SEED.
- Reset mid-read: the pending read is discarded and OUTPUT is forced to 0 asynchronously.
- Read sampled at edge T: OUTPUT changes at edge T+L and holds until the next read completes. Writes never change OUTPUT.
- Back-to-back reads can be sampled every L cycles. A second read at T+L is accepted, and its data appears at T+2L.
- Read-after-write to the same address: write at T, read at T+1. The read returns the new byte in deterministic mode.
- Write at edge T: visible to a read sampled at T+1 or later.
- DMODE and TRNG_MODE are sampled with the access. Changes while in RD_WAIT do not alter the pending read's latency.

## Configuration
- MRAM_EMU_TRNG_EN defined: the LFSR and the stochastic write path are compiled in, as described above.
- MRAM_EMU_TRNG_EN undefined:
  - The LFSR and LFSR_SEED logic are removed.
  - TRNG_MODE is ignored, and every write is deterministic.
  - All other behaviour is identical.

## Structure
- Shared package mram_pkg:
  - Localparams: ROW_W=7, COL_W=4, BYTE_W=8, LFSR_TAPS=32'h8020_0003.
  - State enum {IDLE, RD_WAIT}.
  - Function lat_of(dmode) returning 1..4.
- One natural sub-module: mram_emu_lfsr, a 32-bit Galois LFSR with seed parameter and enable, instantiated only under MRAM_EMU_TRNG_EN.
- The array, state machine and error logic stay in mram_emu.

## Test plan
- Reset and deterministic write/read: rst pulse, then write row 1, col 14, DATA=8'h12; read with DMODE=6'h15 (L=2). Expect OUTPUT=8'h00 after reset, OUTPUT=8'h12 exactly 2 edges after the read, acc_err=0.
- Latency sweep: read the same byte with DMODE[1:0]=0,1,2,3. Expect OUTPUT to update at T+1, T+2, T+3, T+4 respectively.
- Out-of-range access: ROWS=64, write ROW_ADDR=100 with 8'hAA, then read ROW_ADDR=100. Expect a read result of 8'h00 and acc_err=1 held until rst.
- Collision: DMODE=6'h03 (L=4). Read at T and write 8'h55 to another address at T+2. Expect the write dropped (readback unchanged), acc_err=1, and the first read's data at T+4.
- Stochastic write (MRAM_EMU_TRNG_EN defined), starting from a zeroed byte:
  - TRNG_MODE=9'h170 (P=0), write 8'hFF: readback 8'h00.
  - TRNG_MODE=9'h177 (P=7), 1000 writes of 8'hFF then 8'h00: each bit's observed switching rate within 7/16 ± 5%.
  - TRNG_MODE=9'h077: deterministic, readback equals DATA.
- Macro off (MRAM_EMU_TRNG_EN undefined), TRNG_MODE=9'h170, write 8'hA5: readback 8'hA5.
